// File: rtl/hilo_mdu_if.sv
// hilo_mdu_if: EX-stage request bus and HI/LO result bus of the multiply/divide unit
interface hilo_mdu_if #(parameter int WIDTH = 32);
    logic             flush;
    logic             op_valid;
    logic [2:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             op_ready;
    logic             busy;
    logic             div_zero;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    modport master(output flush, op_valid, op, src_a, src_b,
                   input op_ready, busy, div_zero, hi_out, lo_out);
    modport slave(input flush, op_valid, op, src_a, src_b,
                  output op_ready, busy, div_zero, hi_out, lo_out);
endinterface

// File: rtl/hilo_mdu.sv
// hilo_mdu: HI/LO register pair with multi-cycle multiply and radix-2 restoring divide
module hilo_mdu #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 3
) (
    input logic       clk,
    input logic       rst,
    hilo_mdu_if.slave bus
);
    localparam int CW = $clog2((WIDTH > MUL_LAT ? WIDTH : MUL_LAT) + 1);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, hi_q, hi_d, lo_q, lo_d;
    logic             msgn_q, msgn_d, qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
    logic [WIDTH-1:0] ma, mb;
    logic             ms, sa, sb, qbit;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_next;

    assign bus.op_ready = state_q == IDLE;
    assign bus.busy     = state_q != IDLE;
    assign bus.div_zero = dz_q;
    assign bus.hi_out   = hi_q;
    assign bus.lo_out   = lo_q;

    // product and divider datapath; in IDLE the multiplier sees the bus directly so MUL_LAT==1 commits at accept
    always_comb begin
        ma       = state_q == IDLE ? bus.src_a : a_q;
        mb       = state_q == IDLE ? bus.src_b : b_q;
        ms       = state_q == IDLE ? !bus.op[0] : msgn_q;
        prod     = {{WIDTH{ms & ma[WIDTH-1]}}, ma} * {{WIDTH{ms & mb[WIDTH-1]}}, mb};
        trial    = {r_q, a_q[WIDTH-1]} - {1'b0, b_q};
        qbit     = !trial[WIDTH];
        rem_next = qbit ? trial[WIDTH-1:0] : {r_q[WIDTH-2:0], a_q[WIDTH-1]};
        sa       = !bus.op[0] & bus.src_a[WIDTH-1];
        sb       = !bus.op[0] & bus.src_b[WIDTH-1];
    end

    // next-state: accept ops in IDLE, step multiply/divide, commit, flush cancels without commit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        msgn_d  = msgn_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = 1'b0;
        if (bus.flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (bus.op_valid) begin
                    case (bus.op)
                        3'b000, 3'b001: begin
                            a_d    = bus.src_a;
                            b_d    = bus.src_b;
                            msgn_d = !bus.op[0];
                            cnt_d  = CW'(MUL_LAT - 1);
                            if (MUL_LAT == 1) {hi_d, lo_d} = prod;
                            else state_d = MUL;
                        end
                        3'b010, 3'b011: begin
                            if (bus.src_b == '0) dz_d = 1'b1;
                            else begin
                                a_d     = sa ? -bus.src_a : bus.src_a;
                                b_d     = sb ? -bus.src_b : bus.src_b;
                                r_d     = '0;
                                qneg_d  = sa ^ sb;
                                rneg_d  = sa;
                                cnt_d   = CW'(WIDTH);
                                state_d = DIV;
                            end
                        end
                        3'b100: hi_d = bus.src_a;
                        3'b101: lo_d = bus.src_a;
                        default: ;
                    endcase
                end
                MUL: begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        {hi_d, lo_d} = prod;
                        state_d      = IDLE;
                    end
                end
                DIV: begin
                    a_d   = {a_q[WIDTH-2:0], qbit};
                    r_d   = rem_next;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) state_d = FIX;
                end
                FIX: begin
                    lo_d    = qneg_q ? -a_q : a_q;
                    hi_d    = rneg_q ? -r_q : r_q;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // state registers; reset abandons any op in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            msgn_q  <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            msgn_q  <= msgn_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
        end
    end
endmodule

// File: tb/tb_hilo_mdu.sv
// tb_hilo_mdu: vector table, corner sequences and random ops against an arithmetic reference model
module tb_hilo_mdu;
    localparam int ML = 3;
    logic clk = 1'b0, rst = 1'b1, flush = 1'b0, op_valid = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] src_a = '0, src_b = '0;
    int checks = 0, failures = 0;
    logic [31:0] mhi = '0, mlo = '0;
    int   s_nb;
    logic s_dz, s_dz2, s_m1b;
    logic [31:0] s_m1hi, s_m1lo;

    hilo_mdu_if #(.WIDTH(32)) m3 ();
    hilo_mdu_if #(.WIDTH(32)) m1 ();
    assign m3.flush = flush;
    assign m3.op_valid = op_valid;
    assign m3.op = op;
    assign m3.src_a = src_a;
    assign m3.src_b = src_b;
    assign m1.flush = flush;
    assign m1.op_valid = op_valid;
    assign m1.op = op;
    assign m1.src_a = src_a;
    assign m1.src_b = src_b;

    hilo_mdu #(.WIDTH(32), .MUL_LAT(ML)) dut (.clk(clk), .rst(rst), .bus(m3));
    hilo_mdu #(.WIDTH(32), .MUL_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(m1));

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
        int          nb;
        logic        dz;
    } vec_t;
    vec_t tv[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic void ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                   inout logic [31:0] hi, inout logic [31:0] lo,
                                   output int nb, output logic dz);
        longint sa, sb;
        logic [63:0] p;
        nb = 0;
        dz = 1'b0;
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            3'd0: begin p = sa * sb; {hi, lo} = p; nb = ML - 1; end
            3'd1: begin p = {32'b0, a} * {32'b0, b}; {hi, lo} = p; nb = ML - 1; end
            3'd2: if (b == 0) dz = 1'b1;
                  else begin p = sa / sb; lo = p[31:0]; p = sa % sb; hi = p[31:0]; nb = 33; end
            3'd3: if (b == 0) dz = 1'b1;
                  else begin lo = a / b; hi = a % b; nb = 33; end
            3'd4: hi = a;
            3'd5: lo = a;
            default: ;
        endcase
    endfunction

    // present one op for a single cycle, count busy cycles, optionally flush before edge fk+1 after accept
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int fk);
        op_valid = 1'b1;
        op = o;
        src_a = a;
        src_b = b;
        tick();
        op_valid = 1'b0;
        s_dz = m3.div_zero;
        s_m1b = m1.busy;
        s_m1hi = m1.hi_out;
        s_m1lo = m1.lo_out;
        s_nb = 0;
        while (m3.busy && s_nb < 100) begin
            if (s_nb == fk) flush = 1'b1;
            tick();
            flush = 1'b0;
            s_nb++;
        end
        if (s_nb >= 100) chk("busy_timeout", 64'(s_nb), 64'd0);
        tick();
        s_dz2 = m3.div_zero;
    endtask

    initial begin
        logic [31:0] ehi, elo;
        int enb, fk;
        logic edz;
        logic [2:0] o;
        logic [31:0] a, b;
        tv[0] = '{3'd0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 2, 1'b0};
        tv[1] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 2, 1'b0};
        tv[2] = '{3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0};
        tv[3] = '{3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b0};
        tv[4] = '{3'd4, 32'h12345678, 32'd0, 32'h12345678, 32'd14, 0, 1'b0};
        tv[5] = '{3'd5, 32'h12345678, 32'd0, 32'h12345678, 32'h12345678, 0, 1'b0};
        tv[6] = '{3'd2, 32'd5, 32'd0, 32'h12345678, 32'h12345678, 0, 1'b1};
        tv[7] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 33, 1'b0};
        tv[8] = '{3'd6, 32'hDEADBEEF, 32'd1, 32'd0, 32'h80000000, 0, 1'b0};
        tv[9] = '{3'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 33, 1'b0};

        tick();
        tick();
        rst = 1'b0;
        chk("rst_hi", 64'(m3.hi_out), 64'd0);
        chk("rst_lo", 64'(m3.lo_out), 64'd0);
        chk("rst_ready", 64'(m3.op_ready), 64'd1);
        chk("rst_busy", 64'(m3.busy), 64'd0);
        chk("rst_dz", 64'(m3.div_zero), 64'd0);

        for (int i = 0; i < 10; i++) begin
            do_op(tv[i].op, tv[i].a, tv[i].b, -1);
            chk($sformatf("vec%0d_hi", i), 64'(m3.hi_out), 64'(tv[i].hi));
            chk($sformatf("vec%0d_lo", i), 64'(m3.lo_out), 64'(tv[i].lo));
            chk($sformatf("vec%0d_busy", i), 64'(s_nb), 64'(tv[i].nb));
            chk($sformatf("vec%0d_dz", i), 64'(s_dz), 64'(tv[i].dz));
            chk($sformatf("vec%0d_dz_end", i), 64'(s_dz2), 64'd0);
            if (tv[i].op[2:1] == 2'b00) begin
                chk($sformatf("vec%0d_lat1_busy", i), 64'(s_m1b), 64'd0);
                chk($sformatf("vec%0d_lat1_hi", i), 64'(s_m1hi), 64'(tv[i].hi));
                chk($sformatf("vec%0d_lat1_lo", i), 64'(s_m1lo), 64'(tv[i].lo));
            end
        end
        mhi = m3.hi_out;
        mlo = m3.lo_out;
        mhi = 32'd1;
        mlo = 32'h80000000;
        do_op(3'd4, 32'd1, 32'd0, -1);

        // MTHI held valid while a DIVU runs must be ignored
        op_valid = 1'b1;
        op = 3'd3;
        src_a = 32'd100;
        src_b = 32'd7;
        tick();
        op = 3'd4;
        src_a = 32'hA5;
        repeat (5) tick();
        op_valid = 1'b0;
        for (int n = 0; n < 60 && m3.busy; n++) tick();
        chk("mthi_middiv_hi", 64'(m3.hi_out), 64'd2);
        chk("mthi_middiv_lo", 64'(m3.lo_out), 64'd14);
        mhi = 32'd2;
        mlo = 32'd14;

        // flush during the tenth busy cycle of a DIV: no commit
        do_op(3'd2, 32'hFFFFFF00, 32'd3, 9);
        chk("flush_div_nb", 64'(s_nb), 64'd10);
        chk("flush_div_hi", 64'(m3.hi_out), 64'(mhi));
        chk("flush_div_lo", 64'(m3.lo_out), 64'(mlo));
        // flush on the MUL commit edge suppresses the commit
        do_op(3'd0, 32'd9, 32'd9, 1);
        chk("flush_mul_commit_hi", 64'(m3.hi_out), 64'(mhi));
        chk("flush_mul_commit_lo", 64'(m3.lo_out), 64'(mlo));
        chk("flush_mul_ready", 64'(m3.op_ready), 64'd1);
        // flush with an op in IDLE drops it
        op_valid = 1'b1;
        flush = 1'b1;
        op = 3'd4;
        src_a = 32'h77;
        tick();
        op_valid = 1'b0;
        flush = 1'b0;
        chk("flush_idle_hi", 64'(m3.hi_out), 64'(mhi));

        for (int i = 0; i < 200; i++) begin
            o = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 :
                ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if ($urandom_range(0, 9) == 0) a = 32'h80000000;
            if ($urandom_range(0, 9) == 0) b = 32'hFFFFFFFF;
            ehi = mhi;
            elo = mlo;
            ref_op(o, a, b, ehi, elo, enb, edz);
            fk = (enb > 0 && $urandom_range(0, 5) == 0) ? int'($urandom_range(0, enb - 1)) : -1;
            do_op(o, a, b, fk);
            if (fk < 0) begin
                mhi = ehi;
                mlo = elo;
                chk($sformatf("rnd%0d_busy op%0d", i, o), 64'(s_nb), 64'(enb));
                chk($sformatf("rnd%0d_dz op%0d", i, o), 64'(s_dz), 64'(edz));
            end else
                chk($sformatf("rnd%0d_flush_ready", i), 64'(m3.op_ready), 64'd1);
            chk($sformatf("rnd%0d_hi op%0d a=%h b=%h", i, o, a, b), 64'(m3.hi_out), 64'(mhi));
            chk($sformatf("rnd%0d_lo op%0d a=%h b=%h", i, o, a, b), 64'(m3.lo_out), 64'(mlo));
        end

        // reset in the middle of a MUL: nothing committed, registers cleared
        do_op(3'd4, 32'h55, 32'd0, -1);
        op_valid = 1'b1;
        op = 3'd0;
        src_a = 32'd3;
        src_b = 32'd5;
        tick();
        op_valid = 1'b0;
        chk("rstmid_busy", 64'(m3.busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_ready", 64'(m3.op_ready), 64'd1);
        repeat (3) tick();
        chk("rstmid_hi", 64'(m3.hi_out), 64'd0);
        chk("rstmid_lo", 64'(m3.lo_out), 64'd0);
        chk("rstmid_lat1_hi", 64'(m1.hi_out), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
